// File: rtl/adder_chk_pkg.sv
// Shared types and constants for the full-adder result checker.
// Beat layout is {a, b, cin, sum, cout}, MSB first.
package adder_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BIT_A    = 4;
  localparam int BIT_B    = 3;
  localparam int BIT_CIN  = 2;
  localparam int BIT_SUM  = 1;
  localparam int BIT_COUT = 0;
  localparam int BEAT_W   = 5;

  // All-ones value for a counter of width w (w <= 63); callers truncate to width.
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/adder_golden.sv
// Combinational reference model of a 1-bit full adder.
module adder_golden (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic exp_sum,
  output logic exp_cout
);

  assign exp_sum  = a ^ b ^ cin;
  assign exp_cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/adder_result_checker.sv
// Self-checking stage behind a 1-bit full adder: counts beats and mismatches per run.
// First-error capture is built only when ADDER_CHK_FIRST_ERR_EN is defined.
//
// state | meaning
// IDLE  | waiting for start, no beats accepted
// RUN   | accepting beats until NUM_VEC have been seen
// DONE  | results stable, start launches a new run
module adder_result_checker
  import adder_chk_pkg::*;
#(
  parameter int NUM_VEC = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               a,
  input  logic               b,
  input  logic               cin,
  input  logic               sum,
  input  logic               cout,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   vec_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [CNT_W-1:0]   first_err_idx,
  output logic [BEAT_W-1:0]  first_err_vec
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_VEC);
  localparam logic [CNT_W-1:0] ERR_MAX  = CNT_W'(sat_max(CNT_W));

  state_t              state;
  logic [BEAT_W-1:0]   beat;
  logic                exp_sum;
  logic                exp_cout;
  logic                beat_known;
  logic                mismatch;
  logic                hs;
  logic                clear;
  logic [CNT_W-1:0]    vec_nxt;

  assign beat = {a, b, cin, sum, cout};

  adder_golden u_golden (
    .a        (beat[BIT_A]),
    .b        (beat[BIT_B]),
    .cin      (beat[BIT_CIN]),
    .exp_sum  (exp_sum),
    .exp_cout (exp_cout)
  );

  // Any X/Z on the beat poisons the reduction, so unknown data counts as a mismatch.
  assign beat_known = ((^beat) ^ (^beat)) === 1'b0;
  assign mismatch   = !beat_known
                    || (beat[BIT_SUM] !== exp_sum)
                    || (beat[BIT_COUT] !== exp_cout);

  assign in_ready = (state == RUN);
  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign pass     = done && (err_cnt == '0);
  assign hs       = in_valid && in_ready;
  assign clear    = start && (state != RUN);
  assign vec_nxt  = vec_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      vec_cnt <= '0;
      err_cnt <= '0;
    end else if (clear) begin
      state   <= RUN;
      vec_cnt <= '0;
      err_cnt <= '0;
    end else if (hs) begin
      vec_cnt <= vec_nxt;
      if (mismatch && (err_cnt != ERR_MAX))
        err_cnt <= err_cnt + 1'b1;
      if (vec_nxt == LAST_CNT)
        state <= DONE;
    end else if ((state != IDLE) && (state != RUN) && (state != DONE)) begin
      state <= IDLE;
    end
  end

`ifdef ADDER_CHK_FIRST_ERR_EN
  logic first_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_seen    <= 1'b0;
      first_err_idx <= '0;
      first_err_vec <= '0;
    end else if (clear) begin
      first_seen    <= 1'b0;
      first_err_idx <= '0;
      first_err_vec <= '0;
    end else if (hs && mismatch && !first_seen) begin
      first_seen    <= 1'b1;
      first_err_idx <= vec_cnt;
      first_err_vec <= beat;
    end
  end
`else
  assign first_err_idx = '0;
  assign first_err_vec = '0;
`endif

endmodule

// File: tb/tb_adder_result_checker.sv
// Directed bench for adder_result_checker: default instance plus a CNT_W=2, NUM_VEC=3 instance.
module tb_adder_result_checker;

`ifdef ADDER_CHK_FIRST_ERR_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, start1 = 1'b0;
  logic in_valid = 1'b0, in_valid1 = 1'b0;
  logic a = 1'b0, b = 1'b0, cin = 1'b0, sum = 1'b0, cout = 1'b0;

  logic        in_ready, busy, done, pass;
  logic [15:0] vec_cnt, err_cnt, first_err_idx;
  logic [4:0]  first_err_vec;

  logic        in_ready1, busy1, done1, pass1;
  logic [1:0]  vec_cnt1, err_cnt1, first_err_idx1;
  logic [4:0]  first_err_vec1;

  logic ga = 1'b0, gb = 1'b0, gc = 1'b0;
  logic g_sum, g_cout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_result_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
    .busy(busy), .done(done), .pass(pass), .vec_cnt(vec_cnt), .err_cnt(err_cnt),
    .first_err_idx(first_err_idx), .first_err_vec(first_err_vec)
  );

  adder_result_checker #(.NUM_VEC(3), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
    .busy(busy1), .done(done1), .pass(pass1), .vec_cnt(vec_cnt1), .err_cnt(err_cnt1),
    .first_err_idx(first_err_idx1), .first_err_vec(first_err_vec1)
  );

  adder_golden u_model (.a(ga), .b(gb), .cin(gc), .exp_sum(g_sum), .exp_cout(g_cout));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {cout, sum} of a full adder, computed arithmetically.
  function automatic logic [1:0] ref_out(input logic [2:0] v);
    return 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One accepted beat; flip selects output bits to corrupt ({cout,sum} xor flip).
  task automatic beat(input logic [2:0] v, input logic [1:0] flip);
    logic [1:0] o;
    o = ref_out(v) ^ flip;
    {a, b, cin} = v;
    {cout, sum} = o;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {in_ready, busy, done, pass}, 0);
    check({tag, "_vec"}, vec_cnt, 0);
    check({tag, "_err"}, err_cnt, 0);
    check({tag, "_fidx"}, first_err_idx, 0);
    check({tag, "_fvec"}, first_err_vec, 0);
    check({tag, "_outs1"}, {in_ready1, busy1, done1, pass1, vec_cnt1, err_cnt1}, 0);
  endtask

  initial begin
    // Reset state
    #2;
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;

    // Reference model against arithmetic sum
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      {ga, gb, gc} = v;
      #1;
      check($sformatf("golden_%0d", i), {g_cout, g_sum}, ref_out(v));
    end

    // in_valid in IDLE is not consumed
    in_valid = 1'b1;
    tick();
    tick();
    check("idle_ready", in_ready, 0);
    check("idle_vec", vec_cnt, 0);
    in_valid = 1'b0;

    // Exhaustive passing run
    pulse_start();
    check("run1_busy", {busy, in_ready, done}, 3'b110);
    check("run1_vec0", vec_cnt, 0);
    for (int i = 0; i < 8; i++) begin
      beat(3'(i), 2'b00);
      if (i == 0) check("run1_vec1", vec_cnt, 1);
      if (i == 6) check("run1_notdone", {done, busy}, 2'b01);
    end
    check("run1_done", {done, pass, busy, in_ready}, 4'b1100);
    check("run1_vec", vec_cnt, 8);
    check("run1_err", err_cnt, 0);
    tick();
    check("run1_hold", vec_cnt, 8);

    // Restart from DONE with an injected fault at beat 5
    pulse_start();
    check("run2_clear", {busy, done, vec_cnt, err_cnt}, 34'h2_0000_0000);
    for (int i = 0; i < 8; i++)
      beat(3'(i), (i == 5) ? 2'b01 : 2'b00);
    check("run2_done", {done, pass}, 2'b10);
    check("run2_err", err_cnt, 1);
    check("run2_fidx", first_err_idx, CAP ? 5 : 0);
    check("run2_fvec", first_err_vec, CAP ? 5'b10111 : 5'b00000);

    // Gaps, start ignored in RUN, two faults, in_valid held in DONE
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        {a, b, cin, sum, cout} = 5'($urandom_range(0, 31));
        start = (i == 4);
        tick();
        start = 1'b0;
      end
      beat(3'(i), (i == 2 || i == 6) ? 2'b01 : 2'b00);
    end
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    check("gap_vec", vec_cnt, 8);
    check("gap_err", err_cnt, 2);
    check("gap_done", {done, pass}, 2'b10);
    check("gap_fidx", first_err_idx, CAP ? 2 : 0);
    check("gap_fvec", first_err_vec, CAP ? 5'b01000 : 5'b00000);

    // Reset mid-run
    pulse_start();
    beat(3'd1, 2'b11);
    beat(3'd2, 2'b00);
    beat(3'd3, 2'b00);
    check("mid_vec3", vec_cnt, 3);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    tick();
    rst_n = 1'b1;
    pulse_start();
    check("post_rst_vec0", vec_cnt, 0);
    beat(3'd4, 2'b00);
    check("post_rst_vec1", vec_cnt, 1);
    check("post_rst_err", err_cnt, 0);

    // Start coincident with the last beat is ignored
    for (int i = 1; i < 7; i++) beat(3'(i), 2'b00);
    start = 1'b1;
    beat(3'd7, 2'b00);
    start = 1'b0;
    check("coinc_done", {done, busy, pass}, 3'b101);
    check("coinc_vec", vec_cnt, 8);

    // Small instance: every beat wrong reaches the saturation value
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("sat_busy", busy1, 1);
    for (int i = 0; i < 3; i++) begin
      logic [2:0] v;
      v = 3'(i);
      {a, b, cin} = v;
      {cout, sum} = ref_out(v) ^ 2'b11;
      in_valid1 = 1'b1;
      tick();
    end
    in_valid1 = 1'b0;
    check("sat_done", {done1, pass1, busy1}, 3'b100);
    check("sat_vec", vec_cnt1, 3);
    check("sat_err", err_cnt1, 3);
    check("sat_fidx", first_err_idx1, 0);
    check("sat_fvec", first_err_vec1, CAP ? 5'b00011 : 5'b00000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
